serial_frame_receiver: RTL

SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

---
 rtl/serial_pkg.sv | 8 +
 rtl/async_receiver.sv | 83 ++++++++
 rtl/serial_frame_receiver.sv | 70 +++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: frame delimiters and state encodings shared by the receiver and parser.
package serial_pkg;
  localparam logic [7:0] CH_AT = 8'h40;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_LF = 8'h0A;
  typedef enum logic [1:0] {IDLE, GOT_AT, GOT_PAY, GOT_SLASH} parser_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
endpackage

// File: rtl/async_receiver.sv
// async_receiver: 16x-oversampled 8N1 character receiver with framing-error detection.
module async_receiver
  import serial_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr,
  output logic       rx_busy
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  logic [1:0] sync;
  logic rxd_s, rxd_q, tick, valid_n, ferr_n;
  logic [15:0] div_cnt;
  logic [3:0] tick_cnt, tick_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  rx_state_t state, state_n;
  assign rxd_s = sync[1];
  assign tick = div_cnt == 16'(DIV - 1);
  assign rx_data = shift;
  assign rx_busy = state == RX_START || state == RX_DATA || state == RX_STOP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      rxd_q <= 1'b1;
      div_cnt <= '0;
      state <= RX_IDLE;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      sync <= {sync[0], rxd};
      rxd_q <= rxd_s;
      div_cnt <= tick ? '0 : div_cnt + 16'd1;
      state <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift <= shift_n;
      rx_valid <= valid_n;
      rx_ferr <= ferr_n;
    end
  end
  // tick_cnt wraps 15 -> 0 on its own, so data sampling needs no explicit reload
  always_comb begin
    state_n = state;
    tick_cnt_n = tick ? tick_cnt + 4'd1 : tick_cnt;
    bit_cnt_n = bit_cnt;
    shift_n = shift;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      RX_IDLE: if (rxd_q && !rxd_s) begin
        state_n = RX_START;
        tick_cnt_n = '0;
      end
      RX_START: if (tick && tick_cnt == 4'd7) begin
        state_n = rxd_s ? RX_IDLE : RX_DATA;
        tick_cnt_n = '0;
        bit_cnt_n = '0;
      end
      RX_DATA: if (tick && tick_cnt == 4'd15) begin
        shift_n = {rxd_s, shift[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        state_n = bit_cnt == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (tick && tick_cnt == 4'd15) begin
        valid_n = 1'b1;
        ferr_n = !rxd_s;
        state_n = rxd_s ? RX_IDLE : RX_WAIT;
      end
      RX_WAIT: state_n = rxd_s ? RX_IDLE : RX_WAIT;
      default: state_n = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: parses "@<payload>/\n" frames from a serial line, counting errors.
module serial_frame_receiver
  import serial_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       frame_valid,
  output logic [7:0] frame_data,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       rx_busy
);
  logic rx_valid, rx_ferr, fv_n, fe_n;
  logic [7:0] rx_data, payload, payload_n;
  parser_state_t state, state_n;
  async_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ferr(rx_ferr), .rx_busy(rx_busy)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      payload <= '0;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      frame_data <= '0;
      err_count <= '0;
    end else begin
      state <= state_n;
      payload <= payload_n;
      frame_valid <= fv_n;
      frame_err <= fe_n;
      frame_data <= fv_n ? payload : frame_data;
      err_count <= fe_n && err_count != 8'hFF ? err_count + 8'd1 : err_count;
    end
  end
  // a stray '@' mid-frame is taken as the start of the next frame
  always_comb begin
    state_n = state;
    payload_n = payload;
    fv_n = 1'b0;
    fe_n = 1'b0;
    if (rx_valid && rx_ferr) begin
      fe_n = state != IDLE;
      state_n = IDLE;
    end else if (rx_valid) begin
      case (state)
        IDLE: state_n = rx_data == CH_AT ? GOT_AT : IDLE;
        GOT_AT: begin
          payload_n = rx_data;
          state_n = GOT_PAY;
        end
        GOT_PAY: begin
          fe_n = rx_data != CH_SLASH;
          state_n = rx_data == CH_SLASH ? GOT_SLASH : rx_data == CH_AT ? GOT_AT : IDLE;
        end
        GOT_SLASH: begin
          fv_n = rx_data == CH_LF;
          fe_n = rx_data != CH_LF;
          state_n = rx_data == CH_AT && rx_data != CH_LF ? GOT_AT : IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule
